// File: rtl/async_queue_source.sv
// async_queue_source: enqueue side of a gray-pointer asynchronous queue.
// Accepted words are written into a register-file memory that the remote
// (dequeue) domain reads directly. The write index is published as a
// registered gray code. The remote gray read index is brought into this
// domain through a SYNC-deep flop chain and compared against the write
// index to derive full.
//
// Optional feature, enabled by defining ASYNC_QUEUE_SOURCE_SAFE_EN:
//   adds io_async_safe_widx_valid / io_async_safe_ridx_valid so that no
//   word is accepted until the sink domain has signalled it is out of reset.
module async_queue_source #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int SYNC  = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_enq_valid,
  output logic                          io_enq_ready,
  input  logic [WIDTH-1:0]              io_enq_bits,
  output logic [DEPTH*WIDTH-1:0]        io_async_mem,
  output logic [$clog2(DEPTH):0]        io_async_widx,
  input  logic [$clog2(DEPTH):0]        io_async_ridx
`ifdef ASYNC_QUEUE_SOURCE_SAFE_EN
  ,
  output logic                          io_async_safe_widx_valid,
  input  logic                          io_async_safe_ridx_valid
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int P  = AW + 1;

  // Gray codes of two indices exactly DEPTH apart differ only in the top two
  // bits, so full is an equality test against the read index with those
  // two bits inverted.
  localparam logic [P-1:0] ONES = '1;
  localparam logic [P-1:0] MASK = ONES ^ (ONES >> 2);

  function automatic logic [P-1:0] bin2gray(input logic [P-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [P-1:0]          widx_bin_q,  widx_bin_d;
  logic [P-1:0]          widx_gray_q, widx_gray_d;
  logic [SYNC-1:0][P-1:0] ridx_sync_q, ridx_sync_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];

  logic                  full;
  logic                  fire;
  logic                  wr_en;
  logic [P-1:0]          widx_bin_inc;

`ifdef ASYNC_QUEUE_SOURCE_SAFE_EN
  logic                  safe_widx_valid_q, safe_widx_valid_d;
  logic [SYNC-1:0]       ridx_valid_sync_q, ridx_valid_sync_d;
`endif

  // Full and ready depend only on registered state, never on valid/bits.
  always_comb begin
    full = (widx_gray_q == (ridx_sync_q[SYNC-1] ^ MASK));
`ifdef ASYNC_QUEUE_SOURCE_SAFE_EN
    io_enq_ready = !full && ridx_valid_sync_q[SYNC-1];
`else
    io_enq_ready = !full;
`endif
    fire  = io_enq_valid && io_enq_ready;
    // Reset dominates: nothing is written during a reset cycle.
    wr_en = fire && !reset;
  end

  // Next write index: advance binary and gray copies together on a fire.
  always_comb begin
    widx_bin_inc = widx_bin_q + 1'b1;
    widx_bin_d   = widx_bin_q;
    widx_gray_d  = widx_gray_q;
    if (fire) begin
      widx_bin_d  = widx_bin_inc;
      widx_gray_d = bin2gray(widx_bin_inc);
    end
  end

  // Synchronizer shift: stage 0 samples the remote index, the last stage
  // is the only one the comparison looks at.
  always_comb begin
    ridx_sync_d = {ridx_sync_q[SYNC-2:0], io_async_ridx};
  end

  // Memory next state: one entry replaced on an accepted word.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[widx_bin_q[AW-1:0]] = io_enq_bits;
    end
  end

  // Control state: write indices and read-index synchronizer.
  always_ff @(posedge clock) begin
    if (reset) begin
      widx_bin_q  <= '0;
      widx_gray_q <= '0;
      ridx_sync_q <= '0;
    end else begin
      widx_bin_q  <= widx_bin_d;
      widx_gray_q <= widx_gray_d;
      ridx_sync_q <= ridx_sync_d;
    end
  end

  // Data storage is never reset; entries are defined once written.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Memory is presented flat: entry i occupies bits [i*WIDTH +: WIDTH].
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem_out
    assign io_async_mem[gi*WIDTH +: WIDTH] = mem_q[gi];
  end

  assign io_async_widx = widx_gray_q;

`ifdef ASYNC_QUEUE_SOURCE_SAFE_EN
  // Safe-mode handshake next state: local valid rises once out of reset,
  // remote valid is shifted through its own synchronizer.
  always_comb begin
    safe_widx_valid_d = 1'b1;
    ridx_valid_sync_d = {ridx_valid_sync_q[SYNC-2:0], io_async_safe_ridx_valid};
  end

  // Safe-mode handshake registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      safe_widx_valid_q <= 1'b0;
      ridx_valid_sync_q <= '0;
    end else begin
      safe_widx_valid_q <= safe_widx_valid_d;
      ridx_valid_sync_q <= ridx_valid_sync_d;
    end
  end

  assign io_async_safe_widx_valid = safe_widx_valid_q;
`endif

endmodule

// File: tb/tb_async_queue_source.sv
// Directed bench for async_queue_source with DEPTH=8, WIDTH=8, SYNC=3.
// The safe-mode scenario is included when ASYNC_QUEUE_SOURCE_SAFE_EN is set.
module tb_async_queue_source;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int SYNC  = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_enq_valid;
  logic        io_enq_ready;
  logic [7:0]  io_enq_bits;
  logic [63:0] io_async_mem;
  logic [3:0]  io_async_widx;
  logic [3:0]  io_async_ridx;
`ifdef ASYNC_QUEUE_SOURCE_SAFE_EN
  logic        safe_wv;
  logic        safe_rv;
`endif

  int n_vec = 0;
  int n_err = 0;

  async_queue_source #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SYNC(SYNC)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_enq_valid  (io_enq_valid),
    .io_enq_ready  (io_enq_ready),
    .io_enq_bits   (io_enq_bits),
    .io_async_mem  (io_async_mem),
    .io_async_widx (io_async_widx),
    .io_async_ridx (io_async_ridx)
`ifdef ASYNC_QUEUE_SOURCE_SAFE_EN
    ,
    .io_async_safe_widx_valid (safe_wv),
    .io_async_safe_ridx_valid (safe_rv)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leave reset; in safe mode also let the remote-valid synchronizer fill.
  task automatic release_reset();
    reset        = 1'b0;
    io_enq_valid = 1'b0;
    tick();
`ifdef ASYNC_QUEUE_SOURCE_SAFE_EN
    repeat (SYNC - 1) tick();
`endif
  endtask

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  function automatic logic [7:0] ent(input int i);
    return io_async_mem[i*8 +: 8];
  endfunction

  logic [3:0] prev_w;

  initial begin
    reset         = 1'b1;
    io_enq_valid  = 1'b0;
    io_enq_bits   = 8'h00;
    io_async_ridx = 4'b0000;
`ifdef ASYNC_QUEUE_SOURCE_SAFE_EN
    safe_rv = 1'b0;
    // Safe mode: local valid low during reset, high right after.
    tick();
    check("safe_wv_in_reset", safe_wv, 1'b0);
    tick();
    check("safe_wv_in_reset2", safe_wv, 1'b0);
    reset = 1'b0;
    tick();
    check("safe_wv_after_reset", safe_wv, 1'b1);
    io_enq_valid = 1'b1;
    io_enq_bits  = 8'h99;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("safe_ready_blocked%0d", i), io_enq_ready, 1'b0);
      check($sformatf("safe_widx_blocked%0d", i), io_async_widx, 4'b0000);
    end
    io_enq_valid = 1'b0;
    safe_rv = 1'b1;
    tick();
    check("safe_ready_c1", io_enq_ready, 1'b0);
    tick();
    check("safe_ready_c2", io_enq_ready, 1'b0);
    tick();
    check("safe_ready_c3", io_enq_ready, 1'b1);
    reset = 1'b1;
`endif

    // Scenario 1: reset with valid asserted.
    io_enq_valid = 1'b1;
    io_enq_bits  = 8'h77;
    tick();
    check("rst_widx_c1", io_async_widx, 4'b0000);
    tick();
    check("rst_widx_c2", io_async_widx, 4'b0000);
    release_reset();
    check("rst_widx_out", io_async_widx, 4'b0000);
    check("rst_ready_out", io_enq_ready, 1'b1);

    // Scenario 2: single write.
    io_enq_valid = 1'b1;
    io_enq_bits  = 8'hA5;
    tick();
    io_enq_valid = 1'b0;
    check("single_mem0", ent(0), 8'hA5);
    check("single_widx", io_async_widx, 4'b0001);
    check("single_ready", io_enq_ready, 1'b1);

    // Reset mid-operation: no write may land, indices return to 0.
    reset        = 1'b1;
    io_enq_valid = 1'b1;
    io_enq_bits  = 8'h77;
    tick();
    tick();
    check("midrst_widx", io_async_widx, 4'b0000);
    check("midrst_mem0", ent(0), 8'hA5);
    release_reset();
    check("midrst_widx_out", io_async_widx, 4'b0000);

    // Scenario 3: fill to full.
    for (int i = 0; i < 8; i++) begin
      io_enq_valid = 1'b1;
      io_enq_bits  = 8'h10 + 8'(i);
      tick();
      check($sformatf("fill_widx%0d", i), io_async_widx, gray(i + 1));
      check($sformatf("fill_ready%0d", i), io_enq_ready, (i < 7) ? 1'b1 : 1'b0);
    end
    check("fill_mem", io_async_mem, 64'h1716151413121110);
    check("fill_widx_full", io_async_widx, 4'b1100);
    io_enq_bits = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_widx%0d", i), io_async_widx, 4'b1100);
      check($sformatf("hold_mem%0d", i), io_async_mem, 64'h1716151413121110);
      check($sformatf("hold_ready%0d", i), io_enq_ready, 1'b0);
    end

    // Scenario 4: release from full after SYNC cycles.
    io_enq_valid  = 1'b0;
    io_async_ridx = 4'b0001;
    tick();
    check("rel_ready_c1", io_enq_ready, 1'b0);
    tick();
    check("rel_ready_c2", io_enq_ready, 1'b0);
    tick();
    check("rel_ready_c3", io_enq_ready, 1'b1);
    io_enq_valid = 1'b1;
    io_enq_bits  = 8'h20;
    tick();
    io_enq_valid = 1'b0;
    check("rel_widx", io_async_widx, 4'b1101);
    check("rel_mem0", ent(0), 8'h20);
    check("rel_mem1", ent(1), 8'h11);
    check("rel_ready_full", io_enq_ready, 1'b0);

    // Scenario 5: wrap-around with ridx lagging widx by 4 cycles.
    reset         = 1'b1;
    io_async_ridx = 4'b0000;
    tick();
    tick();
    release_reset();
    prev_w = io_async_widx;
    for (int k = 1; k <= 16; k++) begin
      io_async_ridx = (k - 1 >= 4) ? gray(k - 5) : 4'b0000;
      io_enq_valid  = 1'b1;
      io_enq_bits   = 8'h30 + 8'(k - 1);
      tick();
      check($sformatf("wrap_widx%0d", k), io_async_widx, gray(k));
      check($sformatf("wrap_onebit%0d", k), $countones(prev_w ^ io_async_widx), 1);
      check($sformatf("wrap_ready%0d", k), io_enq_ready, 1'b1);
      if (k == 9) check("wrap_mem0_at_wrap", ent(0), 8'h38);
      prev_w = io_async_widx;
    end
    io_enq_valid = 1'b0;
    check("wrap_widx_end", io_async_widx, 4'b0000);
    check("wrap_mem0_end", ent(0), 8'h38);
    check("wrap_mem7_end", ent(7), 8'h3F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
